// File: rtl/irq_arbiter_pkg.sv
// Shared definitions for the interrupt arbiter: register offsets and FSM states.
package irq_arbiter_pkg;

    // Word offsets of the memory-mapped registers (bridge address bits [3:2]).
    typedef enum logic [1:0] {
        REG_MASK    = 2'd0,
        REG_PENDING = 2'd1,
        REG_SERVICE = 2'd2,
        REG_RAW     = 2'd3
    } reg_addr_e;

    // Request/acknowledge/EOI handshake states towards CP0.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } state_e;

endpackage

// File: rtl/irq_arbiter_if.sv
// Bus and CP0 handshake signals of the interrupt arbiter.
// master: bridge/CPU side; slave: the arbiter itself.
interface irq_arbiter_if #(
    parameter int ID_W = 3
);
    logic [1:0]      addr;
    logic            we;
    logic [31:0]     din;
    logic [31:0]     dout;
    logic            int_req;
    logic [ID_W-1:0] int_id;
    logic            int_ack;

    modport master (
        output addr, we, din, int_ack,
        input  dout, int_req, int_id
    );

    modport slave (
        input  addr, we, din, int_ack,
        output dout, int_req, int_id
    );
endinterface

// File: rtl/irq_arbiter_prio_enc.sv
// Lowest-index-first priority encoder with a valid flag; purely combinational.
module irq_arbiter_prio_enc #(
    parameter int N    = 6,
    parameter int ID_W = 3
) (
    input  logic [N-1:0]    req,
    output logic [ID_W-1:0] sel,
    output logic            valid
);

    // Scan from the top down so the lowest set index is the last assignment to stick.
    always_comb begin
        // NOTE: default assignment first, so every path drives sel and no latch is inferred.
        sel = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                sel = ID_W'(i);
            end
        end
    end

    assign valid = |req;

endmodule

// File: rtl/irq_arbiter.sv
// Interrupt arbiter: sticky edge-captured pending bits, software mask,
// fixed-priority selection and a req/ack/EOI handshake with CP0.
// N_SRC must be 1..8 and 2**ID_W >= N_SRC; the interface must use the same ID_W.
module irq_arbiter
    import irq_arbiter_pkg::*;
#(
    parameter int N_SRC = 6,
    parameter int ID_W  = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_SRC-1:0] irq_in,
    irq_arbiter_if.slave     bus
);

    state_e           state, state_next;
    logic [ID_W-1:0]  id_q, id_next;
    logic [N_SRC-1:0] mask_q;
    logic [N_SRC-1:0] pending_q, pending_next;
    logic [N_SRC-1:0] irq_prev;

    logic [N_SRC-1:0] rise;
    logic [N_SRC-1:0] eligible;
    logic [N_SRC-1:0] id_onehot;
    logic [N_SRC-1:0] w1c_clr;
    logic [N_SRC-1:0] ack_clr;
    logic [ID_W-1:0]  sel;
    logic             sel_valid;
    logic             wr_mask;
    logic             wr_pending;
    logic             eoi;

    // Upper din bits carry no meaning for an N_SRC-wide register.
    logic unused_din;
    assign unused_din = ^bus.din;

    assign wr_mask    = bus.we && (bus.addr == REG_MASK);
    assign wr_pending = bus.we && (bus.addr == REG_PENDING);
    assign eoi        = bus.we && (bus.addr == REG_SERVICE);

    assign rise      = irq_in & ~irq_prev;
    assign eligible  = pending_q & mask_q;
    assign id_onehot = N_SRC'(1) << id_q;
    assign w1c_clr   = wr_pending ? bus.din[N_SRC-1:0] : '0;

    irq_arbiter_prio_enc #(
        .N    (N_SRC),
        .ID_W (ID_W)
    ) u_prio_enc (
        .req   (eligible),
        .sel   (sel),
        .valid (sel_valid)
    );

    // FSM state and latched id; id only changes when a new request is issued.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: non-blocking assignments for all state, so every register samples pre-edge values.
            state <= ST_IDLE;
            id_q  <= '0;
        end else begin
            state <= state_next;
            id_q  <= id_next;
        end
    end

    // Next-state logic; arbitration uses this cycle's (pre-write) mask and pending.
    always_comb begin
        state_next = state;
        id_next    = id_q;
        ack_clr    = '0;
        unique case (state)
            ST_IDLE: begin
                if (sel_valid) begin
                    state_next = ST_REQ;
                    id_next    = sel;
                end
            end
            ST_REQ: begin
                if (bus.int_ack) begin
                    ack_clr    = id_onehot;
                    state_next = ST_SERVICE;
                end else if ((eligible & id_onehot) == '0) begin
                    // Requested source was masked or cleared: withdraw and re-arbitrate.
                    state_next = ST_IDLE;
                end
            end
            ST_SERVICE: begin
                if (eoi) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Pending update: clears first, then a fresh rising edge overrides them.
    assign pending_next = (pending_q & ~w1c_clr & ~ack_clr) | rise;

    // Register file and edge-detect history.
    always_ff @(posedge clk) begin
        if (reset) begin
            mask_q    <= '0;
            pending_q <= '0;
            irq_prev  <= '0;
        end else begin
            irq_prev  <= irq_in;
            pending_q <= pending_next;
            if (wr_mask) begin
                mask_q <= bus.din[N_SRC-1:0];
            end
        end
    end

    // Read mux, combinational from addr; narrower fields zero-extend.
    always_comb begin
        bus.dout = '0;
        unique case (bus.addr)
            REG_MASK:    bus.dout = 32'(mask_q);
            REG_PENDING: bus.dout = 32'(pending_q);
            REG_SERVICE: bus.dout = {state == ST_SERVICE, {(31 - ID_W){1'b0}}, id_q};
            REG_RAW:     bus.dout = 32'(irq_in);
            default:     bus.dout = '0;
        endcase
    end

    assign bus.int_req = (state == ST_REQ);
    assign bus.int_id  = id_q;

endmodule

// File: tb/tb_irq_arbiter.sv
// Self-checking bench for irq_arbiter: directed scenarios followed by random
// traffic, all compared against a behavioural model of the register/handshake rules.
module tb_irq_arbiter;

    localparam int N  = 6;
    localparam int IW = 3;

    localparam int S_IDLE = 0;
    localparam int S_REQ  = 1;
    localparam int S_SVC  = 2;

    logic         clk = 1'b0;
    logic         reset;
    logic [N-1:0] irq_in;

    irq_arbiter_if #(.ID_W(IW)) bus ();

    irq_arbiter #(
        .N_SRC (N),
        .ID_W  (IW)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .irq_in (irq_in),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Behavioural model state.
    logic [N-1:0] m_mask;
    logic [N-1:0] m_pend;
    logic [N-1:0] m_prev;
    int           m_state;
    int           m_id;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_mask  = '0;
        m_pend  = '0;
        m_prev  = '0;
        m_state = S_IDLE;
        m_id    = 0;
    endfunction

    function automatic logic [31:0] model_dout(input logic [1:0] a);
        logic [31:0] v;
        case (a)
            2'd0:    v = 32'(m_mask);
            2'd1:    v = 32'(m_pend);
            2'd2: begin
                v     = 32'(m_id);
                v[31] = (m_state == S_SVC);
            end
            default: v = 32'(irq_in);
        endcase
        return v;
    endfunction

    // One clock edge of the reference behaviour, from the inputs currently applied.
    function automatic void model_step();
        int           sel;
        logic [N-1:0] np;
        if (reset) begin
            model_reset();
            return;
        end
        sel = -1;
        for (int i = 0; i < N; i++) begin
            if (sel < 0 && m_pend[i] && m_mask[i]) sel = i;
        end
        np = m_pend;
        if (bus.we && bus.addr == 2'd1) begin
            for (int i = 0; i < N; i++) if (bus.din[i]) np[i] = 1'b0;
        end
        case (m_state)
            S_IDLE: if (sel >= 0) begin
                m_state = S_REQ;
                m_id    = sel;
            end
            S_REQ: begin
                if (bus.int_ack) begin
                    np[m_id] = 1'b0;
                    m_state  = S_SVC;
                end else if (!(m_pend[m_id] && m_mask[m_id])) begin
                    m_state = S_IDLE;
                end
            end
            default: if (bus.we && bus.addr == 2'd2) m_state = S_IDLE;
        endcase
        for (int i = 0; i < N; i++) begin
            if (irq_in[i] && !m_prev[i]) np[i] = 1'b1;
        end
        if (bus.we && bus.addr == 2'd0) m_mask = bus.din[N-1:0];
        m_prev = irq_in;
        m_pend = np;
    endfunction

    // Apply inputs for one cycle, check the read port, clock, then check the CP0 outputs.
    task automatic drive(input logic [N-1:0] irq, input logic w, input logic [1:0] a,
                         input logic [31:0] d, input logic ack);
        irq_in      = irq;
        bus.we      = w;
        bus.addr    = a;
        bus.din     = d;
        bus.int_ack = ack;
        #1;
        check("dout", bus.dout, model_dout(a));
        @(posedge clk);
        model_step();
        #1;
        check("int_req", 32'(bus.int_req), 32'(m_state == S_REQ));
        check("int_id", 32'(bus.int_id), m_id);
    endtask

    task automatic idle(input logic [N-1:0] irq);
        drive(irq, 1'b0, 2'd0, 32'd0, 1'b0);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        drive('0, 1'b1, a, d, 1'b0);
    endtask

    task automatic ack();
        drive('0, 1'b0, 2'd0, 32'd0, 1'b1);
    endtask

    task automatic expect_reg(input string tag, input logic [1:0] a, input logic [31:0] exp);
        bus.we      = 1'b0;
        bus.addr    = a;
        bus.int_ack = 1'b0;
        #1;
        check(tag, bus.dout, exp);
    endtask

    initial begin
        int           n_req;
        logic         prev_req;
        logic [N-1:0] irq_cur;

        reset       = 1'b1;
        irq_in      = '0;
        bus.we      = 1'b0;
        bus.addr    = 2'd0;
        bus.din     = '0;
        bus.int_ack = 1'b0;
        repeat (2) @(posedge clk);
        model_reset();
        #1;
        reset = 1'b0;

        // Reset state.
        check("rst_int_req", 32'(bus.int_req), 32'd0);
        check("rst_int_id", 32'(bus.int_id), 32'd0);
        expect_reg("rst_mask", 2'd0, 32'd0);
        expect_reg("rst_pending", 2'd1, 32'd0);
        expect_reg("rst_service", 2'd2, 32'd0);

        // Masked source pends without requesting; unmasking requests two cycles later.
        idle(6'h04);
        idle(6'h00);
        expect_reg("masked_pending", 2'd1, 32'h4);
        check("masked_no_req", 32'(bus.int_req), 32'd0);
        wr(2'd0, 32'h4);
        idle(6'h00);
        check("unmask_req", 32'(bus.int_req), 32'd1);
        check("unmask_id", 32'(bus.int_id), 32'd2);
        ack();
        wr(2'd2, 32'd0);

        // Simultaneous rises: lowest index wins; ack, service readback, EOI re-request.
        wr(2'd0, 32'h3F);
        idle(6'h0A);
        idle(6'h00);
        check("prio_id", 32'(bus.int_id), 32'd1);
        ack();
        expect_reg("svc_pending", 2'd1, 32'h8);
        expect_reg("svc_readback", 2'd2, 32'h8000_0001);
        wr(2'd2, 32'd0);
        idle(6'h00);
        check("eoi_rereq", 32'(bus.int_req), 32'd1);
        check("eoi_rereq_id", 32'(bus.int_id), 32'd3);
        ack();
        wr(2'd2, 32'd0);

        // Masking the requested source withdraws the request; unmasking re-requests.
        idle(6'h10);
        idle(6'h00);
        check("id4_req", 32'(bus.int_id), 32'd4);
        wr(2'd0, 32'h0F);
        check("withdraw_prewrite", 32'(bus.int_req), 32'd1);
        idle(6'h00);
        check("withdraw_req", 32'(bus.int_req), 32'd0);
        expect_reg("withdraw_pending", 2'd1, 32'h10);
        wr(2'd0, 32'h3F);
        idle(6'h00);
        check("rearb_req", 32'(bus.int_req), 32'd1);
        check("rearb_id", 32'(bus.int_id), 32'd4);
        ack();
        wr(2'd2, 32'd0);

        // Rising edge beats a same-cycle W1C.
        wr(2'd0, 32'h0);
        idle(6'h01);
        idle(6'h00);
        drive(6'h01, 1'b1, 2'd1, 32'h1, 1'b0);
        expect_reg("rise_beats_w1c", 2'd1, 32'h1);
        drive(6'h00, 1'b1, 2'd1, 32'h1, 1'b0);
        expect_reg("w1c_clears", 2'd1, 32'h0);

        // Ack outside REQ and EOI outside SERVICE are ignored.
        ack();
        check("idle_ack_req", 32'(bus.int_req), 32'd0);
        check("idle_ack_id", 32'(bus.int_id), 32'd4);
        wr(2'd0, 32'h3F);
        idle(6'h04);
        idle(6'h00);
        wr(2'd2, 32'd0);
        check("req_eoi_req", 32'(bus.int_req), 32'd1);
        check("req_eoi_id", 32'(bus.int_id), 32'd2);
        ack();
        wr(2'd2, 32'd0);

        // A held level produces exactly one request across ack and EOI.
        n_req    = 0;
        prev_req = bus.int_req;
        for (int i = 0; i < 20; i++) begin
            drive(6'h20, m_state == S_SVC, 2'd2, 32'd0, m_state == S_REQ);
            if (bus.int_req && !prev_req) n_req++;
            prev_req = bus.int_req;
        end
        check("held_level_reqs", 32'(n_req), 32'd1);

        // Reset while in service clears everything.
        idle(6'h00);
        idle(6'h20);
        idle(6'h00);
        ack();
        expect_reg("pre_reset_svc", 2'd2, 32'h8000_0005);
        reset = 1'b1;
        idle(6'h00);
        reset = 1'b0;
        check("post_reset_req", 32'(bus.int_req), 32'd0);
        expect_reg("post_reset_svc", 2'd2, 32'd0);
        expect_reg("post_reset_mask", 2'd0, 32'd0);

        // Random traffic against the model.
        irq_cur = '0;
        for (int i = 0; i < 800; i++) begin
            irq_cur ^= N'($urandom & $urandom);
            reset = ($urandom_range(0, 199) == 0);
            drive(irq_cur,
                  $urandom_range(0, 3) == 0,
                  2'($urandom_range(0, 3)),
                  $urandom,
                  (m_state == S_REQ) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 15) == 0));
        end
        reset = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
